instr_encoder: RTL and testbench

//  Streaming LEGv8 instruction encoder. It is the inverse of the decode stage: it packs an

---
 rtl/instr_encoder.sv | 153 +++++++++++++++
 tb/tb_instr_encoder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Streaming LEGv8 instruction encoder with range-checked immediates and a 2-entry output buffer.
// Latency: a beat accepted at edge N is presented on out_* after edge N (when the buffer was empty).
// Backpressure: in_ready is registered and drops while both entries are held; no push while full.
//
// Ports:
//   clk, rst_n           clock; synchronous active-low reset
//   in_valid/in_ready    input handshake; in_op/in_rd/in_rn/in_rm/in_imm carry the beat fields
//   out_valid/out_ready  output handshake; out_instr/out_err describe the head word
//   instr_cnt, err_cnt   saturating counts of emitted words and emitted error words
module instr_encoder #(
  parameter int IMM_W = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rn,
  input  logic [4:0]       in_rm,
  input  logic [IMM_W-1:0] in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_ORR  = 3'd3;
  localparam logic [2:0] OP_LDUR = 3'd4;
  localparam logic [2:0] OP_STUR = 3'd5;
  localparam logic [2:0] OP_CBZ  = 3'd6;
  localparam logic [2:0] OP_B    = 3'd7;

  // Buffer occupancy states
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [31:0] enc_instr;
  logic        enc_err;
  logic [31:0] head_instr;
  logic        head_err;
  logic [31:0] tail_instr;
  logic        tail_err;
  logic        push;
  logic        pop;

  // An immediate fits in k signed bits when every bit from k-1 upward equals the sign.
  logic fit_d;
  logic fit_cb;
  logic fit_b;
  assign fit_d  = (&in_imm[IMM_W-1:8])  | ~(|in_imm[IMM_W-1:8]);
  assign fit_cb = (&in_imm[IMM_W-1:18]) | ~(|in_imm[IMM_W-1:18]);
  assign fit_b  = (&in_imm[IMM_W-1:25]) | ~(|in_imm[IMM_W-1:25]);

  always_comb begin
    enc_instr = 32'h0;
    enc_err   = 1'b0;
    case (in_op)
      OP_ADD: enc_instr = {11'b10001011000, in_rm, 6'b0, in_rn, in_rd};
      OP_SUB: enc_instr = {11'b11001011000, in_rm, 6'b0, in_rn, in_rd};
      OP_AND: enc_instr = {11'b10001010000, in_rm, 6'b0, in_rn, in_rd};
      OP_ORR: enc_instr = {11'b10101010000, in_rm, 6'b0, in_rn, in_rd};
      OP_LDUR: begin
        if (fit_d) enc_instr = {11'b11111000010, in_imm[8:0], 2'b00, in_rn, in_rd};
        else       enc_err   = 1'b1;
      end
      OP_STUR: begin
        if (fit_d) enc_instr = {11'b11111000000, in_imm[8:0], 2'b00, in_rn, in_rd};
        else       enc_err   = 1'b1;
      end
      OP_CBZ: begin
        if (fit_cb) enc_instr = {8'b10110100, in_imm[18:0], in_rd};
        else        enc_err   = 1'b1;
      end
      OP_B: begin
        if (fit_b) enc_instr = {6'b000101, in_imm[25:0]};
        else       enc_err   = 1'b1;
      end
    endcase
  end

  assign out_valid = (state != EMPTY);
  assign out_instr = head_instr;
  assign out_err   = head_err;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (push) state_nxt = ONE;
      ONE: begin
        if (push && !pop)      state_nxt = FULL;
        else if (pop && !push) state_nxt = EMPTY;
      end
      FULL:    if (pop) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= EMPTY;
      in_ready   <= 1'b1;
      head_instr <= 32'h0;
      head_err   <= 1'b0;
      tail_instr <= 32'h0;
      tail_err   <= 1'b0;
      instr_cnt  <= '0;
      err_cnt    <= '0;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt != FULL);
      // Head is always entry 0; the second entry shifts forward on a pop from FULL.
      case (state)
        EMPTY: begin
          if (push) begin
            head_instr <= enc_instr;
            head_err   <= enc_err;
          end
        end
        ONE: begin
          if (push && pop) begin
            head_instr <= enc_instr;
            head_err   <= enc_err;
          end else if (push) begin
            tail_instr <= enc_instr;
            tail_err   <= enc_err;
          end
        end
        FULL: begin
          if (pop) begin
            head_instr <= tail_instr;
            head_err   <= tail_err;
          end
        end
        default: ;
      endcase
      if (pop && (instr_cnt != '1)) instr_cnt <= instr_cnt + 1'b1;
      if (pop && head_err && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

  typedef struct packed {
    logic [2:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rn;
    logic [4:0]  rm;
    logic [31:0] imm;
    logic [31:0] exp_instr;
    logic        exp_err;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [4:0]  in_rd;
  logic [4:0]  in_rn;
  logic [4:0]  in_rm;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic [4:0]  instr_cnt;
  logic [4:0]  err_cnt;

  int checks = 0;
  int errors = 0;

  instr_encoder #(.IMM_W(32), .CNT_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_rd     (in_rd),
    .in_rn     (in_rn),
    .in_rm     (in_rm),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err),
    .instr_cnt (instr_cnt),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    in_op  = v.op;
    in_rd  = v.rd;
    in_rn  = v.rn;
    in_rm  = v.rm;
    in_imm = v.imm;
  endtask

  task automatic test_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL reset_out_instr got %h want 00000000", out_instr); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL reset_out_err got %b want 0", out_err); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (instr_cnt !== 5'd0) begin errors++; $display("FAIL reset_instr_cnt got %0d want 0", instr_cnt); end
    checks++; if (err_cnt !== 5'd0) begin errors++; $display("FAIL reset_err_cnt got %0d want 0", err_cnt); end
  endtask

  // Streaming with out_ready high: each beat replaces the previous head one edge later.
  task automatic test_encode();
    vec_t v[7];
    v[0] = '{3'd4, 5'd9,  5'd22, 5'd0,  32'd64,         32'hF84402C9, 1'b0};
    v[1] = '{3'd1, 5'd11, 5'd20, 5'd10, 32'd0,          32'hCB0A028B, 1'b0};
    v[2] = '{3'd6, 5'd11, 5'd0,  5'd0,  32'hFFFF_FFFB,  32'hB4FFFF6B, 1'b0};
    v[3] = '{3'd7, 5'd0,  5'd0,  5'd0,  32'd64,         32'h14000040, 1'b0};
    v[4] = '{3'd7, 5'd3,  5'd4,  5'd5,  32'hFFFF_FFC9,  32'h17FFFFC9, 1'b0};
    v[5] = '{3'd5, 5'd1,  5'd2,  5'd0,  32'hFFFF_FF00,  32'hF8100041, 1'b0};
    v[6] = '{3'd2, 5'd0,  5'd1,  5'd2,  32'h1234_5678,  32'h8A020020, 1'b0};
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drive(v[i]);
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL encode[%0d]_valid got %b want 1", i, out_valid); end
      checks++; if (out_instr !== v[i].exp_instr) begin errors++; $display("FAIL encode[%0d]_instr got %h want %h", i, out_instr, v[i].exp_instr); end
      checks++; if (out_err !== v[i].exp_err) begin errors++; $display("FAIL encode[%0d]_err got %b want %b", i, out_err, v[i].exp_err); end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL encode_drain_valid got %b want 0", out_valid); end
    checks++; if (instr_cnt !== 5'd7) begin errors++; $display("FAIL encode_instr_cnt got %0d want 7", instr_cnt); end
    checks++; if (err_cnt !== 5'd0) begin errors++; $display("FAIL encode_err_cnt got %0d want 0", err_cnt); end
  endtask

  task automatic test_range();
    vec_t v[9];
    v[0] = '{3'd4, 5'd9,  5'd22, 5'd0, 32'd256,        32'h0,        1'b1};
    v[1] = '{3'd0, 5'd10, 5'd19, 5'd9, 32'd0,          32'h8B09026A, 1'b0};
    v[2] = '{3'd4, 5'd0,  5'd0,  5'd0, 32'd255,        32'hF84FF000, 1'b0};
    v[3] = '{3'd5, 5'd1,  5'd2,  5'd0, 32'hFFFF_FEFF,  32'h0,        1'b1};
    v[4] = '{3'd6, 5'd3,  5'd0,  5'd0, 32'h0004_0000,  32'h0,        1'b1};
    v[5] = '{3'd6, 5'd0,  5'd0,  5'd0, 32'hFFFC_0000,  32'hB4800000, 1'b0};
    v[6] = '{3'd7, 5'd0,  5'd0,  5'd0, 32'h0200_0000,  32'h0,        1'b1};
    v[7] = '{3'd7, 5'd0,  5'd0,  5'd0, 32'hFE00_0000,  32'h16000000, 1'b0};
    v[8] = '{3'd7, 5'd0,  5'd0,  5'd0, 32'h01FF_FFFF,  32'h15FFFFFF, 1'b0};
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 9; i++) begin
      drive(v[i]);
      tick();
      checks++; if (out_instr !== v[i].exp_instr) begin errors++; $display("FAIL range[%0d]_instr got %h want %h", i, out_instr, v[i].exp_instr); end
      checks++; if (out_err !== v[i].exp_err) begin errors++; $display("FAIL range[%0d]_err got %b want %b", i, out_err, v[i].exp_err); end
      if (i == 1) begin
        checks++; if (err_cnt !== 5'd1) begin errors++; $display("FAIL range_first_err_cnt got %0d want 1", err_cnt); end
      end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (instr_cnt !== 5'd16) begin errors++; $display("FAIL range_instr_cnt got %0d want 16", instr_cnt); end
    checks++; if (err_cnt !== 5'd4) begin errors++; $display("FAIL range_err_cnt got %0d want 4", err_cnt); end
  endtask

  task automatic test_backpressure();
    vec_t orr_v, add_v, and_v;
    orr_v = '{3'd3, 5'd9, 5'd10, 5'd21, 32'd0, 32'hAA150149, 1'b0};
    add_v = '{3'd0, 5'd9, 5'd22, 5'd10, 32'd0, 32'h8B0A02C9, 1'b0};
    and_v = '{3'd2, 5'd0, 5'd1,  5'd2,  32'd0, 32'h8A020020, 1'b0};
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(orr_v);
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_one_in_ready got %b want 1", in_ready); end
    drive(add_v);
    tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_in_ready got %b want 0", in_ready); end
    checks++; if (out_instr !== 32'hAA150149) begin errors++; $display("FAIL bp_head_instr got %h want AA150149", out_instr); end
    // Offer another beat while full and stalled; it must be ignored and the head held.
    drive(and_v);
    tick();
    checks++; if (out_instr !== 32'hAA150149) begin errors++; $display("FAIL bp_hold_instr got %h want AA150149", out_instr); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid got %b want 1", out_valid); end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    checks++; if (out_instr !== 32'h8B0A02C9) begin errors++; $display("FAIL bp_second_instr got %h want 8B0A02C9", out_instr); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_after_pop_in_ready got %b want 1", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain_valid got %b want 0", out_valid); end
    checks++; if (instr_cnt !== 5'd18) begin errors++; $display("FAIL bp_instr_cnt got %0d want 18", instr_cnt); end
  endtask

  task automatic test_full_same_cycle();
    vec_t and_v, b_v, stur_v;
    and_v  = '{3'd2, 5'd0, 5'd1, 5'd2, 32'd0,         32'h8A020020, 1'b0};
    b_v    = '{3'd7, 5'd0, 5'd0, 5'd0, 32'd64,        32'h14000040, 1'b0};
    stur_v = '{3'd5, 5'd1, 5'd2, 5'd0, 32'hFFFF_FF00, 32'hF8100041, 1'b0};
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(and_v);
    tick();
    drive(b_v);
    tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fsc_full_in_ready got %b want 0", in_ready); end
    drive(stur_v);
    out_ready = 1'b1;
    tick();
    checks++; if (out_instr !== 32'h14000040) begin errors++; $display("FAIL fsc_head_instr got %h want 14000040", out_instr); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fsc_in_ready got %b want 1", in_ready); end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fsc_no_push_valid got %b want 0", out_valid); end
    checks++; if (instr_cnt !== 5'd20) begin errors++; $display("FAIL fsc_instr_cnt got %0d want 20", instr_cnt); end
  endtask

  task automatic test_reset_mid();
    vec_t a_v, b_v;
    a_v = '{3'd4, 5'd9, 5'd22, 5'd0, 32'd64,  32'hF84402C9, 1'b0};
    b_v = '{3'd4, 5'd9, 5'd22, 5'd0, 32'd256, 32'h0,        1'b1};
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(a_v);
    tick();
    drive(b_v);
    tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rmid_full_in_ready got %b want 0", in_ready); end
    rst_n = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_out_valid got %b want 0", out_valid); end
    checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL rmid_out_instr got %h want 00000000", out_instr); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready got %b want 1", in_ready); end
    checks++; if (instr_cnt !== 5'd0) begin errors++; $display("FAIL rmid_instr_cnt got %0d want 0", instr_cnt); end
    checks++; if (err_cnt !== 5'd0) begin errors++; $display("FAIL rmid_err_cnt got %0d want 0", err_cnt); end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_post_valid got %b want 0", out_valid); end
  endtask

  // 40 error beats push both counters past their 5-bit ceiling of 31.
  task automatic test_saturate();
    vec_t e_v;
    e_v = '{3'd7, 5'd0, 5'd0, 5'd0, 32'h0200_0000, 32'h0, 1'b1};
    out_ready = 1'b1;
    in_valid  = 1'b1;
    drive(e_v);
    for (int i = 0; i < 40; i++) tick();
    in_valid = 1'b0;
    tick();
    checks++; if (instr_cnt !== 5'd31) begin errors++; $display("FAIL sat_instr_cnt got %0d want 31", instr_cnt); end
    checks++; if (err_cnt !== 5'd31) begin errors++; $display("FAIL sat_err_cnt got %0d want 31", err_cnt); end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_op     = 3'd0;
    in_rd     = 5'd0;
    in_rn     = 5'd0;
    in_rm     = 5'd0;
    in_imm    = 32'd0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    test_reset();
    test_encode();
    test_range();
    test_backpressure();
    test_full_same_cycle();
    test_reset_mid();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
